// File: rtl/rf_ckpt_ctrl.sv
// Register-file checkpoint controller: ring of snapshot slots with commit and one-cycle restore.
// Optional sticky ERR output is enabled by defining NCPU_CKPT_ERR_EN.
module rf_ckpt_ctrl #(
    parameter int DW = 1,
    parameter int AW = 2,
    parameter int CW = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DW*(1<<AW)-1:0]   RF_DO,
    output logic                    RF_REP,
    output logic [DW*(1<<AW)-1:0]   RF_DI,
    input  logic                    CKPT_REQ,
    output logic                    CKPT_RDY,
    output logic [CW-1:0]           CKPT_ID,
    input  logic                    CMT,
    input  logic                    RECOV,
    input  logic [CW-1:0]           RECOV_ID,
    output logic                    BUSY,
`ifdef NCPU_CKPT_ERR_EN
    output logic                    ERR,
`endif
    output logic [CW:0]             COUNT
);

    localparam int          NUM_CKPT = 1 << CW;
    localparam int          IW       = DW * (1 << AW);
    localparam logic [CW:0] FULL_C   = (CW+1)'(NUM_CKPT);
    localparam logic [CW:0] ONE_C    = (CW+1)'(1);
    localparam logic [CW:0] ZERO_C   = (CW+1)'(0);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   head_q, head_d;
    logic [CW-1:0]   tail_q, tail_d;
    logic [CW:0]     count_q, count_d;
    logic [IW-1:0]   rf_di_q, rf_di_d;
    logic [IW-1:0]   slot_q [NUM_CKPT];

    logic            rdy_s;
    logic            push_s;
    logic            pop_s;
    logic            slot_we_s;
    logic [CW-1:0]   recov_off_s;
    logic            recov_ok_s;

    // A restore target is legal only if it lies within the allocated window [head, tail).
    assign recov_off_s = RECOV_ID - head_q;
    assign recov_ok_s  = ({1'b0, recov_off_s} < count_q);

    assign rdy_s  = (count_q != FULL_C) & ~RECOV & (state_q == ST_IDLE);
    assign push_s = CKPT_REQ & rdy_s;
    assign pop_s  = CMT & (count_q != ZERO_C) & ~RECOV & (state_q == ST_IDLE);

    // Next-state computation for the ring pointers, restore image and FSM.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rf_di_d   = rf_di_q;
        slot_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RECOV) begin
                    if (recov_ok_s) begin
                        rf_di_d = slot_q[RECOV_ID];
                        tail_d  = RECOV_ID;
                        count_d = {1'b0, recov_off_s};
                        state_d = ST_RESTORE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (push_s) begin
                        slot_we_s = 1'b1;
                        tail_d    = tail_q + CW'(1);
                    end else begin
                        tail_d    = tail_q;
                    end
                    if (pop_s) begin
                        head_d = head_q + CW'(1);
                    end else begin
                        head_d = head_q;
                    end
                    case ({push_s, pop_s})
                        2'b10:   count_d = count_q + ONE_C;
                        2'b01:   count_d = count_q - ONE_C;
                        default: count_d = count_q;
                    endcase
                end
            end
            ST_RESTORE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Control state; slot storage is intentionally left out of reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            head_q  <= {CW{1'b0}};
            tail_q  <= {CW{1'b0}};
            count_q <= {(CW+1){1'b0}};
            rf_di_q <= {IW{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rf_di_q <= rf_di_d;
        end
    end

    // Snapshot capture into the slot at the tail.
    always_ff @(posedge CLK) begin
        if (slot_we_s) begin
            slot_q[tail_q] <= RF_DO;
        end
    end

`ifdef NCPU_CKPT_ERR_EN
    logic err_q, err_d;
    logic err_set_s;

    assign err_set_s = (state_q == ST_IDLE) &
                       ((RECOV & ~recov_ok_s) | (~RECOV & CMT & (count_q == ZERO_C)));

    // Sticky error flag.
    always_comb begin
        if (err_set_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`endif

    assign CKPT_RDY = rdy_s;
    assign CKPT_ID  = tail_q;
    assign RF_REP   = (state_q == ST_RESTORE);
    assign BUSY     = (state_q == ST_RESTORE);
    assign RF_DI    = rf_di_q;
    assign COUNT    = count_q;

endmodule

// File: tb/tb_rf_ckpt_ctrl.sv
// Self-checking bench for rf_ckpt_ctrl (DW=8, AW=2, CW=2): directed scenarios then random traffic
// checked against a head/count queue model of the checkpoint ring.
module tb_rf_ckpt_ctrl;

    logic        CLK;
    logic        RST;
    logic [31:0] RF_DO;
    logic        RF_REP;
    logic [31:0] RF_DI;
    logic        CKPT_REQ;
    logic        CKPT_RDY;
    logic [1:0]  CKPT_ID;
    logic        CMT;
    logic        RECOV;
    logic [1:0]  RECOV_ID;
    logic        BUSY;
    logic [2:0]  COUNT;
`ifdef NCPU_CKPT_ERR_EN
    logic        ERR;
`endif

    rf_ckpt_ctrl #(.DW(8), .AW(2), .CW(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RF_DO    (RF_DO),
        .RF_REP   (RF_REP),
        .RF_DI    (RF_DI),
        .CKPT_REQ (CKPT_REQ),
        .CKPT_RDY (CKPT_RDY),
        .CKPT_ID  (CKPT_ID),
        .CMT      (CMT),
        .RECOV    (RECOV),
        .RECOV_ID (RECOV_ID),
        .BUSY     (BUSY),
`ifdef NCPU_CKPT_ERR_EN
        .ERR      (ERR),
`endif
        .COUNT    (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: oldest slot index, number of live slots, slot contents.
    int          head_m;
    int          cnt_m;
    logic        restore_m;
    logic        err_m;
    logic [31:0] rdi_m;
    logic [31:0] slot_m [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        CKPT_REQ = 1'b0;
        CMT      = 1'b0;
        RECOV    = 1'b0;
        RECOV_ID = 2'd0;
        RST      = 1'b0;
        #2;
        head_m    = 0;
        cnt_m     = 0;
        restore_m = 1'b0;
        err_m     = 1'b0;
        rdi_m     = 32'h0;
        chk("rst_rf_rep", RF_REP, 1'b0);
        chk("rst_busy",   BUSY,   1'b0);
        chk("rst_count",  COUNT,  3'd0);
        chk("rst_rf_di",  RF_DI,  32'h0);
        chk("rst_id",     CKPT_ID, 2'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic req, input logic cmt, input logic recov,
                        input logic [1:0] id, input logic [31:0] d);
        int   tail_m;
        int   off;
        logic rdy_m;
        logic push;
        logic pop;
        CKPT_REQ = req;
        CMT      = cmt;
        RECOV    = recov;
        RECOV_ID = id;
        RF_DO    = d;
        #1;
        tail_m = (head_m + cnt_m) % 4;
        rdy_m  = (cnt_m != 4) && !recov && !restore_m;
        chk("ckpt_rdy", CKPT_RDY, rdy_m);
        chk("ckpt_id",  CKPT_ID,  tail_m);
        @(posedge CLK);
        if (restore_m) begin
            restore_m = 1'b0;
        end else if (recov) begin
            off = (int'(id) - head_m + 4) % 4;
            if (off < cnt_m) begin
                rdi_m     = slot_m[id];
                cnt_m     = off;
                restore_m = 1'b1;
            end else begin
                err_m = 1'b1;
            end
        end else begin
            push = req && rdy_m;
            pop  = cmt && (cnt_m != 0);
            if (cmt && cnt_m == 0) err_m = 1'b1;
            if (push) slot_m[tail_m] = d;
            if (pop) head_m = (head_m + 1) % 4;
            cnt_m = cnt_m + int'(push) - int'(pop);
        end
        #1;
        chk("rf_rep", RF_REP, restore_m);
        chk("busy",   BUSY,   restore_m);
        chk("rf_di",  RF_DI,  rdi_m);
        chk("count",  COUNT,  cnt_m);
`ifdef NCPU_CKPT_ERR_EN
        chk("err",    ERR,    err_m);
`endif
    endtask

    initial begin
        RF_DO = 32'h0;
        do_reset();

        // Fill all four slots.
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h11111111);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h22222222);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h33333333);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h44444444);
        chk("full_count", COUNT, 3'd4);
        chk("full_rdy",   CKPT_RDY, 1'b0);

        // Full: request refused, commit accepted.
        step(1'b1, 1'b1, 1'b0, 2'd0, 32'h55555555);
        chk("full_cmt_count", COUNT, 3'd3);

        // Restore slot 1 with slots 0..3 held.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h11111111);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h22222222);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h33333333);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h44444444);
        step(1'b1, 1'b1, 1'b1, 2'd1, 32'h66666666);
        chk("rec_rf_rep", RF_REP, 1'b1);
        chk("rec_busy",   BUSY,   1'b1);
        chk("rec_rf_di",  RF_DI,  32'h22222222);
        chk("rec_count",  COUNT,  3'd1);
        chk("rec_id",     CKPT_ID, 2'd1);
        step(1'b1, 1'b1, 1'b1, 2'd0, 32'h77777777);
        chk("rec_done_rep",   RF_REP, 1'b0);
        chk("rec_done_count", COUNT,  3'd1);

        // Wrap: head=3, tail=1, restore slot 0.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 32'hA0A0A0A0 + 32'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'hC0DEC0DE);
        chk("wrap_pre_count", COUNT, 3'd2);
        chk("wrap_pre_tail",  CKPT_ID, 2'd1);
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        chk("wrap_count", COUNT, 3'd1);
        chk("wrap_tail",  CKPT_ID, 2'd0);
        chk("wrap_rf_di", RF_DI, 32'hC0DEC0DE);

        // Illegal restore with nothing allocated.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 2'd2, 32'h0);
        chk("illegal_rep",   RF_REP, 1'b0);
        chk("illegal_count", COUNT,  3'd0);
`ifdef NCPU_CKPT_ERR_EN
        chk("illegal_err",   ERR,    1'b1);
`endif

        // Reset asserted in the middle of a restore.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h12345678);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h9ABCDEF0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        chk("abort_pre_rep", RF_REP, 1'b1);
        #2;
        do_reset();
        chk("abort_rep", RF_REP, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        chk("abort_after_rep", RF_REP, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 32'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_ckpt_ctrl.md
RF_CKPT_CTRL -- requirements
Module: rf_ckpt_ctrl

Interface
REQ-001 SHALL have parameter DW, default 1, meaning register data width.
REQ-002 SHALL have parameter AW, default 2, meaning register address width, giving 1<<AW registers.
REQ-003 SHALL have parameter CW, default 2, meaning checkpoint index width, giving NUM_CKPT=1<<CW slots.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port RF_DO, input, DW*(1<<AW): live register-file image.
REQ-007 SHALL have port RF_REP, output, 1 bit: register-file bulk-replace strobe.
REQ-008 SHALL have port RF_DI, output, DW*(1<<AW): restore image.
REQ-009 SHALL have port CKPT_REQ, input, 1 bit: request snapshot.
REQ-010 SHALL have port CKPT_RDY, output, 1 bit: snapshot slot available.
REQ-011 SHALL have port CKPT_ID, output, CW bits: slot id granted, valid when CKPT_REQ&CKPT_RDY.
REQ-012 SHALL have port CMT, input, 1 bit: retire oldest checkpoint.
REQ-013 SHALL have port RECOV, input, 1 bit: restore request.
REQ-014 SHALL have port RECOV_ID, input, CW bits: slot to restore.
REQ-015 SHALL have port BUSY, output, 1 bit: restore in progress.
REQ-016 SHALL have port COUNT, output, CW+1 bits: allocated slots.

Function
REQ-017 SHALL keep slots as a ring: head (oldest), tail (next free), count; indices wrap modulo NUM_CKPT.
REQ-018 SHALL drive CKPT_RDY = (count!=NUM_CKPT) & ~RECOV & state==IDLE, combinationally.
REQ-019 SHALL drive CKPT_ID = tail; on CKPT_REQ&CKPT_RDY, at the edge, slot[tail]<=RF_DO, tail<=tail+1.
REQ-020 SHALL, on CMT with count!=0 and no RECOV, advance head<=head+1; CMT with count==0 ignored.
REQ-021 SHALL, on simultaneous accepted CKPT_REQ and CMT, apply both, leaving count unchanged.
REQ-022 SHALL implement FSM IDLE->RESTORE on RECOV in IDLE; RESTORE->IDLE unconditionally next cycle.
REQ-023 SHALL, on RECOV accept, register RF_DI<=slot[RECOV_ID], set tail<=RECOV_ID, and set count<=(RECOV_ID-head) mod NUM_CKPT, freeing RECOV_ID and all younger slots.
REQ-024 SHALL assert RF_REP=1 and BUSY=1 for exactly the RESTORE cycle (latency 1 from RECOV), otherwise 0.
REQ-025 SHALL give RECOV priority over CKPT_REQ and CMT in the same cycle; CMT that cycle is dropped.
REQ-026 SHALL ignore RECOV, CMT and CKPT_REQ while in RESTORE.
REQ-027 SHALL treat RECOV_ID outside [head, tail) as illegal: no state change, no RF_REP.
REQ-028 SHALL maintain COUNT = count with a width rule: CW+1 bits, so full reads NUM_CKPT.

Reset
REQ-029 SHALL, on RST low (async), force head=0, tail=0, count=0, state IDLE, RF_REP=0, BUSY=0, RF_DI=0.
REQ-030 SHALL not reset slot storage; a restore aborted by reset mid-RESTORE SHALL produce no RF_REP after release.

Configuration
REQ-031 SHALL, with NCPU_CKPT_ERR_EN defined, add output ERR (1 bit, sticky, reset 0) set by illegal RECOV_ID or CMT when count==0; without it, ERR is absent and such events are silently ignored.

Verification (DW=8, AW=2, CW=2)
REQ-032 SHALL cover: reset, then 4 CKPT_REQ with RF_DO=0x11111111..0x44444444 -> CKPT_ID 0,1,2,3, COUNT=4, CKPT_RDY=0.
REQ-033 SHALL cover: full, CKPT_REQ+CMT same cycle -> CMT accepted, request refused (CKPT_RDY=0), COUNT=3, head=1.
REQ-034 SHALL cover: slots 0..3 held, RECOV_ID=1 -> next cycle RF_REP=1, RF_DI=0x22222222, BUSY=1, COUNT=1, then CKPT_ID=1.
REQ-035 SHALL cover: wrap — head=3, tail=1, RECOV_ID=0 -> COUNT=1, tail=0, RF_DI=slot0 image.
REQ-036 SHALL cover: RECOV_ID=2 with count=0 -> no RF_REP, COUNT=0, ERR=1 only when NCPU_CKPT_ERR_EN is defined.
REQ-037 SHALL cover: RST low during RESTORE -> RF_REP=0, BUSY=0, COUNT=0 immediately, without waiting for CLK.
